// File: rtl/disp_value_formatter_if.sv
// Bundle between the programmer core and the display formatter:
// format request in, committed digits, decimal points and status out.
interface disp_value_formatter_if;
   logic [15:0] value;
   logic        dec_mode;
   logic [3:0]  dp_in;
   logic        load;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [3:0]  seg0;
   logic [3:0]  seg1;
   logic [3:0]  seg2;
   logic [3:0]  seg3;
   logic [3:0]  dp;

   modport master (
      output value, dec_mode, dp_in, load,
      input  busy, done, ovf, seg0, seg1, seg2, seg3, dp
   );

   modport slave (
      input  value, dec_mode, dp_in, load,
      output busy, done, ovf, seg0, seg1, seg2, seg3, dp
   );
endinterface

// File: rtl/disp_value_formatter.sv
// Formats a 16-bit status value into four hex or BCD digits for the 7-seg driver.
// Optional DISP_BLINK_EN adds a heartbeat on dp[0] from a BLINK_BITS-wide counter.
module disp_value_formatter
`ifdef DISP_BLINK_EN
#(
   parameter int BLINK_BITS = 24
)
`endif
(
   input logic                   clk,
   input logic                   rst,
   disp_value_formatter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } state_t;

   state_t      state_reg;
   logic [15:0] bin_reg;
   logic [15:0] bcd_reg;
   logic [4:0]  cnt_reg;
   logic [3:0]  dp_cap_reg;
   logic        ovf_cap_reg;
   logic [3:0]  seg_reg [4];
   logic [3:0]  dp_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        ovf_reg;

   logic [15:0] bcd_adj;
   logic [15:0] bcd_next;
   logic [15:0] bin_next;
   logic        accept;

   // A new request is taken in IDLE and also on the commit edge, so
   // back-to-back loads do not lose a cycle.
   assign accept = bus.load && (state_reg != CONV);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_dabble
         assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                     (bcd_reg[gi*4 +: 4] + 4'd3) :
                                     bcd_reg[gi*4 +: 4];
      end
   endgenerate

   assign bcd_next = {bcd_adj[14:0], bin_reg[15]};
   assign bin_next = {bin_reg[14:0], 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         bin_reg     <= '0;
         bcd_reg     <= '0;
         cnt_reg     <= '0;
         dp_cap_reg  <= '0;
         ovf_cap_reg <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            seg_reg[i] <= '0;
         end
         dp_reg      <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         ovf_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;

         case (state_reg)
            CONV: begin
               bcd_reg <= bcd_next;
               bin_reg <= bin_next;
               cnt_reg <= cnt_reg + 5'd1;
               if (cnt_reg == 5'd15) begin
                  state_reg <= COMMIT;
               end
            end
            COMMIT: begin
               for (int i = 0; i < 4; i++) begin
                  seg_reg[i] <= ovf_cap_reg ? 4'hE : bcd_reg[i*4 +: 4];
               end
               dp_reg    <= dp_cap_reg;
               ovf_reg   <= ovf_cap_reg;
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
            end
         endcase

         // Placed after the case so a request on the commit edge takes priority.
         if (accept) begin
            if (!bus.dec_mode) begin
               for (int i = 0; i < 4; i++) begin
                  seg_reg[i] <= bus.value[i*4 +: 4];
               end
               dp_reg   <= bus.dp_in;
               ovf_reg  <= 1'b0;
               done_reg <= 1'b1;
            end else begin
               bin_reg     <= bus.value;
               bcd_reg     <= '0;
               dp_cap_reg  <= bus.dp_in;
               ovf_cap_reg <= (bus.value > 16'd9999);
               cnt_reg     <= '0;
               busy_reg    <= 1'b1;
               state_reg   <= CONV;
            end
         end
      end
   end

   assign bus.seg0 = seg_reg[0];
   assign bus.seg1 = seg_reg[1];
   assign bus.seg2 = seg_reg[2];
   assign bus.seg3 = seg_reg[3];
   assign bus.busy = busy_reg;
   assign bus.done = done_reg;
   assign bus.ovf  = ovf_reg;

`ifdef DISP_BLINK_EN
   logic [BLINK_BITS-1:0] blink_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_reg <= '0;
      end else begin
         blink_reg <= blink_reg + {{(BLINK_BITS-1){1'b0}}, 1'b1};
      end
   end

   assign bus.dp = {dp_reg[3:1], dp_reg[0] ^ blink_reg[BLINK_BITS-1]};
`else
   assign bus.dp = dp_reg;
`endif

endmodule

// File: tb/tb_disp_value_formatter.sv
// Directed bench for disp_value_formatter: hex/decimal formatting, overflow,
// busy-time loads, reset abort and the dp[0] heartbeat option.
module tb_disp_value_formatter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   check_cnt = 0;
   int   pass_cnt = 0;

   disp_value_formatter_if bus ();

`ifdef DISP_BLINK_EN
   disp_value_formatter #(.BLINK_BITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   localparam logic [3:0] DP_MASK = 4'b1110;
`else
   disp_value_formatter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   localparam logic [3:0] DP_MASK = 4'b1111;
`endif

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_cnt++;
      if (got === exp) begin
         pass_cnt++;
         $display("ok   %-14s got=%0h", tag, got);
      end else begin
         $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] segs();
      return {bus.seg3, bus.seg2, bus.seg1, bus.seg0};
   endfunction

   // Presents a request for one edge (E0); returns on the negedge after E0.
   // Inputs are scrambled afterwards to show they are not re-sampled.
   task automatic start_load(input logic [15:0] v, input logic dm, input logic [3:0] dpv);
      @(negedge clk);
      bus.value    = v;
      bus.dec_mode = dm;
      bus.dp_in    = dpv;
      bus.load     = 1'b1;
      @(negedge clk);
      bus.load     = 1'b0;
      bus.value    = 16'h5A5A;
      bus.dp_in    = ~dpv;
      bus.dec_mode = ~dm;
   endtask

   task automatic wait_done(output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      while (!bus.done && lat < 60) begin
         if (bus.busy) busy_n++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_dec(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                          input logic [15:0] exp_seg, input logic exp_ovf);
      int lat;
      int bn;
      start_load(v, 1'b1, dpv);
      wait_done(lat, bn);
      check({tag, "_lat"}, lat, 17);
      check({tag, "_busyn"}, bn, 17);
      check({tag, "_seg"}, segs(), exp_seg);
      check({tag, "_ovf"}, bus.ovf, exp_ovf);
      check({tag, "_dp"}, bus.dp & DP_MASK, dpv & DP_MASK);
      check({tag, "_busy0"}, bus.busy, 1'b0);
      @(negedge clk);
      check({tag, "_done1"}, bus.done, 1'b0);
   endtask

   initial begin
      int lat;
      int bn;
      int done_cnt;
      logic s [48];
      int t;

      bus.value    = '0;
      bus.dec_mode = 1'b0;
      bus.dp_in    = '0;
      bus.load     = 1'b0;

      // Load asserted during reset must be ignored.
      repeat (2) @(negedge clk);
      bus.load = 1'b1;
      bus.value = 16'h1234;
      @(negedge clk);
      bus.load = 1'b0;
      rst = 1'b0;
      check("rst_seg", segs(), 16'h0000);
      check("rst_dp", bus.dp & DP_MASK, 4'h0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_ovf", bus.ovf, 1'b0);

      // Hex pass-through: latency 1, no busy.
      start_load(16'hBEEF, 1'b0, 4'b0100);
      check("hex_done", bus.done, 1'b1);
      check("hex_busy", bus.busy, 1'b0);
      check("hex_seg", segs(), 16'hBEEF);
      check("hex_dp", bus.dp & DP_MASK, 4'b0100 & DP_MASK);
      check("hex_ovf", bus.ovf, 1'b0);
      @(negedge clk);
      check("hex_done1", bus.done, 1'b0);
      check("hex_busy1", bus.busy, 1'b0);

      run_dec("d1234", 16'd1234, 4'b1010, 16'h1234, 1'b0);
      run_dec("d0", 16'd0, 4'b0001, 16'h0000, 1'b0);
      run_dec("d9999", 16'd9999, 4'b1000, 16'h9999, 1'b0);
      run_dec("d10000", 16'd10000, 4'b0010, 16'hEEEE, 1'b1);

      // Reset held two cycles mid-conversion: no done, outputs cleared.
      start_load(16'd1234, 1'b1, 4'b1111);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("mrst_seg", segs(), 16'h0000);
      check("mrst_dp", bus.dp & DP_MASK, 4'h0);
      check("mrst_busy", bus.busy, 1'b0);
      check("mrst_ovf", bus.ovf, 1'b0);
      done_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.done) done_cnt++;
         @(negedge clk);
      end
      check("mrst_nodone", done_cnt, 0);

      run_dec("d10000b", 16'd10000, 4'b0000, 16'hEEEE, 1'b1);
      run_dec("d42", 16'd42, 4'b0000, 16'h0042, 1'b0);

      // Load of 777 at E5 is dropped; load at E17 is taken.
      start_load(16'd500, 1'b1, 4'b0000);
      repeat (4) @(negedge clk);
      bus.value = 16'd777;
      bus.dec_mode = 1'b1;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      done_cnt = 0;
      for (int k = 5; k < 16; k++) begin
         if (bus.done) done_cnt++;
         @(negedge clk);
      end
      if (bus.done) done_cnt++;
      bus.value = 16'd777;
      bus.dec_mode = 1'b1;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      check("bsy_early", done_cnt, 0);
      check("bsy_done", bus.done, 1'b1);
      check("bsy_seg", segs(), 16'h0500);
      check("b2b_busy", bus.busy, 1'b1);
      @(negedge clk);
      wait_done(lat, bn);
      check("b2b_lat", lat, 16);
      check("b2b_seg", segs(), 16'h0777);
      check("b2b_ovf", bus.ovf, 1'b0);

      // Heartbeat on dp[0] with committed dp = 0.
      start_load(16'h0000, 1'b0, 4'b0000);
      for (int k = 0; k < 48; k++) begin
         s[k] = bus.dp[0];
         @(negedge clk);
      end
`ifdef DISP_BLINK_EN
      t = 0;
      while (t < 9 && s[t] == s[0]) t++;
      check("blk_edge", (t < 9), 1'b1);
      for (int k = 0; k < 32; k += 4) begin
         check("blk_phase", s[t + k], s[t] ^ ((k / 8) % 2 == 1));
      end
      check("blk_hi", bus.dp[3:1], 3'b000);
`else
      t = 0;
      for (int k = 0; k < 48; k++) begin
         if (s[k] !== 1'b0) t++;
      end
      check("dp0_const", t, 0);
      check("dp_all", bus.dp, 4'b0000);
`endif

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
